dmac_read: RTL and testbench

DMA read engine: accepts a transfer command from the DMA controller, issues one AXI4 read burst from the source address, and buffers the returned beats in an internal FIFO. The FIFO output is a valid/ready beat stream consumed directly by the DMA write engine, which drives it onto its W channel. One burst per command; `define.sv` supplies all bus widths.

---
 rtl/define.sv | 9 +
 rtl/dmac_read.sv | 163 ++++++++++++++++
 tb/tb_dmac_read.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/define.sv
// Bus widths shared by the DMA engines.
`ifndef DMAC_DEFINE_SV
`define DMAC_DEFINE_SV
`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`define LEN_BITS   8
`define SIZE_BITS  3
`define ID_BITS    4
`endif

// File: rtl/dmac_read.sv
// DMA read engine: one AXI4 read burst per command, beats buffered in a FIFO
// and streamed to the write engine over a valid/ready interface.
`ifndef DMAC_DEFINE_SV
`include "define.sv"
`endif

// state  | meaning
// S_IDLE | waiting for a command
// S_AR   | read address presented, waiting for m_arready
// S_R    | accepting read beats into the FIFO (or discarding after a missing last)
// S_DRAIN| burst finished, waiting for the FIFO to empty
module dmac_read #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  input  logic [`ADDR_WIDTH-1:0] src_addr_i,
  input  logic [`LEN_BITS-1:0]   len_i,
  input  logic [`SIZE_BITS-1:0]  size_i,
  input  logic [1:0]             burst_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [`ID_BITS-1:0]    m_arid,
  output logic [`ADDR_WIDTH-1:0] m_araddr,
  output logic [`LEN_BITS-1:0]   m_arlen,
  output logic [`SIZE_BITS-1:0]  m_arsize,
  output logic [1:0]             m_arburst,
  output logic                   m_arvalid,
  input  logic                   m_arready,
  input  logic [`ID_BITS-1:0]    m_rid,
  input  logic [`DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]             m_rresp,
  input  logic                   m_rlast,
  input  logic                   m_rvalid,
  output logic                   m_rready,
  output logic [`DATA_WIDTH-1:0] data_o,
  output logic                   data_valid_o,
  input  logic                   data_ready_i
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [`LEN_BITS-1:0]   cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   discard_q, discard_d;
  logic                   latch_cmd;
  logic                   push;
  logic                   pop;
  logic                   last_pop;
  logic                   r_acc;
  logic                   full;
  logic                   empty;
  logic [AW:0]            wr_ptr_q, rd_ptr_q;
  logic [AW:0]            rd_ptr_inc;
  logic [`DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                   unused_rid;

  assign unused_rid = ^m_rid;

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_ptr_inc = rd_ptr_q + 1'b1;

  assign m_arid       = '0;
  assign m_arvalid    = (state_q == S_AR);
  // Discard mode keeps the R channel draining even when the FIFO is full.
  assign m_rready     = (state_q == S_R) && (discard_q || !full);
  assign r_acc        = m_rvalid && m_rready;
  assign busy_o       = (state_q != S_IDLE);
  assign error_o      = err_q;
  assign data_valid_o = !empty;
  assign data_o       = mem[rd_ptr_q[AW-1:0]];
  assign pop          = data_valid_o && data_ready_i;
  assign last_pop     = pop && (rd_ptr_inc == wr_ptr_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    discard_d = discard_q;
    latch_cmd = 1'b0;
    push      = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          latch_cmd = 1'b1;
          cnt_d     = len_i;
          err_d     = 1'b0;
          discard_d = 1'b0;
          state_d   = S_AR;
        end
      end
      S_AR: begin
        if (m_arready) state_d = S_R;
      end
      S_R: begin
        if (r_acc) begin
          if (m_rresp != 2'b00) err_d = 1'b1;
          if (discard_q) begin
            if (m_rlast) state_d = S_DRAIN;
          end else begin
            push = 1'b1;
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            if (m_rlast) begin
              state_d = S_DRAIN;
              if (cnt_q != '0) err_d = 1'b1;
            end else if (cnt_q == '0) begin
              err_d     = 1'b1;
              discard_d = 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        // done_o follows the final pop in the same cycle, so it sees data_ready_i.
        if (empty || last_pop) begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      discard_q <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      discard_q <= discard_d;
      if (latch_cmd) begin
        m_araddr  <= src_addr_i;
        m_arlen   <= len_i;
        m_arsize  <= size_i;
        m_arburst <= burst_i;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= m_rdata;
  end

endmodule

// File: tb/tb_dmac_read.sv
// Self-checking bench for dmac_read: directed and randomized bursts against a
// transaction-level model of expected beats, errors and completion.
`ifndef DMAC_DEFINE_SV
`include "define.sv"
`endif

module tb_dmac_read;

  localparam int DEPTH = 4;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   valid_i;
  logic [`ADDR_WIDTH-1:0] src_addr_i;
  logic [`LEN_BITS-1:0]   len_i;
  logic [`SIZE_BITS-1:0]  size_i;
  logic [1:0]             burst_i;
  logic                   busy_o, done_o, error_o;
  logic [`ID_BITS-1:0]    m_arid;
  logic [`ADDR_WIDTH-1:0] m_araddr;
  logic [`LEN_BITS-1:0]   m_arlen;
  logic [`SIZE_BITS-1:0]  m_arsize;
  logic [1:0]             m_arburst;
  logic                   m_arvalid, m_arready;
  logic [`ID_BITS-1:0]    m_rid;
  logic [`DATA_WIDTH-1:0] m_rdata;
  logic [1:0]             m_rresp;
  logic                   m_rlast, m_rvalid, m_rready;
  logic [`DATA_WIDTH-1:0] data_o;
  logic                   data_valid_o, data_ready_i;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  dmac_read #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .src_addr_i(src_addr_i),
    .len_i(len_i), .size_i(size_i), .burst_i(burst_i), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_error"}, error_o, 1'b0);
    chk({tag, "_arvalid"}, m_arvalid, 1'b0);
    chk({tag, "_rready"}, m_rready, 1'b0);
    chk({tag, "_araddr"}, m_araddr, 0);
    chk({tag, "_arlen"}, m_arlen, 0);
    chk({tag, "_arsize"}, m_arsize, 0);
    chk({tag, "_arburst"}, m_arburst, 0);
    chk({tag, "_dvalid"}, data_valid_o, 1'b0);
    chk({tag, "_arid"}, m_arid, 0);
  endtask

  // mode 0: normal burst; 1: rlast on beat index arg; 2: arg extra beats after the expected last.
  task automatic run_burst(input logic [31:0] addr, input int len, input int size, input int burst,
                           input int mode, input int arg, input int err_idx, input int stall,
                           input int cons_delay, input bit rnd, input bit second_valid,
                           input bit chk_full, input logic [31:0] dbase);
    logic [31:0] bdat [64];
    logic [1:0]  bresp[64];
    logic [31:0] q[$];
    int n_send, n_push, si, occ, cyc, ar_cnt;
    bit ar_done, last_seen, exp_err, fin, pop;

    n_send = len + 1; n_push = len + 1;
    if (mode == 1) begin n_send = arg + 1; n_push = arg + 1; end
    if (mode == 2) n_send = len + 1 + arg;
    for (int i = 0; i < n_send; i++) begin
      bdat[i]  = (dbase != 0) ? dbase + i : $urandom;
      bresp[i] = (i == err_idx) ? 2'b10 : 2'b00;
    end
    exp_err = (mode == 2) || (mode == 1 && arg < len) || (err_idx >= 0 && err_idx < n_send);
    si = 0; occ = 0; cyc = 0; ar_cnt = 0;
    ar_done = 0; last_seen = 0; fin = 0;

    @(negedge clk_i);
    valid_i = 1'b1; src_addr_i = addr;
    len_i = len[`LEN_BITS-1:0]; size_i = size[`SIZE_BITS-1:0]; burst_i = burst[1:0];
    data_ready_i = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
    @(negedge clk_i);
    valid_i = 1'b0;
    src_addr_i = $urandom;
    chk("start_busy", busy_o, 1'b1);
    chk("start_arvalid", m_arvalid, 1'b1);
    chk("start_error_clear", error_o, 1'b0);
    chk("start_arlen", m_arlen, len);
    chk("start_arsize", m_arsize, size);
    chk("start_arburst", m_arburst, burst);

    while (!fin && cyc < 400) begin
      if (cyc > 0) @(negedge clk_i);
      chk("busy", busy_o, 1'b1);
      chk("dvalid", data_valid_o, occ != 0);
      if (occ != 0) chk("data", data_o, q[0]);
      valid_i = second_valid && (cyc == 2);
      if (valid_i) src_addr_i = ~addr;
      m_arready = !ar_done && (rnd ? ($urandom_range(0, 1) == 1) : (cyc >= stall));
      m_rvalid  = ar_done && (si < n_send) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      m_rdata   = (si < n_send) ? bdat[si] : 32'h0;
      m_rresp   = (si < n_send) ? bresp[si] : 2'b00;
      m_rlast   = (si == n_send - 1);
      m_rid     = 4'(si);
      data_ready_i = (cyc >= cons_delay) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      #1;
      pop = data_valid_o && data_ready_i;
      if (!ar_done) begin
        chk("ar_valid_held", m_arvalid, 1'b1);
        chk("ar_addr_stable", m_araddr, addr);
        chk("rready_before_ar", m_rready, 1'b0);
      end else if (!last_seen) begin
        if (si > len) chk("rready_discard", m_rready, 1'b1);
        else          chk("rready_space", m_rready, occ < DEPTH);
      end else begin
        chk("rready_drain", m_rready, 1'b0);
      end
      chk("done", done_o, last_seen && (occ == 0 || (occ == 1 && pop)));
      if (chk_full && cyc == cons_delay - 1) chk("beats_until_full", si, DEPTH);
      if (m_arvalid && m_arready) begin ar_cnt++; ar_done = 1; end
      if (pop) begin q.pop_front(); occ--; end
      if (m_rvalid && m_rready) begin
        if (si < n_push) begin q.push_back(bdat[si]); occ++; end
        if (si == n_send - 1) last_seen = 1;
        si++;
      end
      if (done_o) fin = 1;
      cyc++;
    end
    chk("done_seen", fin, 1'b1);
    chk("ar_count", ar_cnt, 1);
    chk("beats_sent", si, n_send);
    chk("all_delivered", q.size(), 0);
    @(negedge clk_i);
    valid_i = 1'b0; data_ready_i = 1'b0; m_rvalid = 1'b0; m_arready = 1'b0;
    chk("end_busy", busy_o, 1'b0);
    chk("end_done", done_o, 1'b0);
    chk("end_error", error_o, exp_err);
    chk("end_dvalid", data_valid_o, 1'b0);
  endtask

  initial begin
    int len, mode, arg, eidx;
    rst_ni = 1'b0; valid_i = 1'b0; src_addr_i = '0; len_i = '0; size_i = '0; burst_i = '0;
    m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    data_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk_reset_state("reset");
    rst_ni = 1'b1;

    // basic INCR burst with fixed data
    run_burst(32'h1000, 3, 2, 1, 0, 0, -1, 0, 0, 0, 0, 0, 32'hA0);
    // consumer stalled: FIFO fills and m_rready drops
    run_burst(32'h2000, 7, 2, 1, 0, 0, -1, 0, 15, 0, 0, 1, 32'h0);
    // AR stall with an ignored second command
    run_burst(32'h3000, 2, 3, 1, 0, 0, -1, 5, 0, 0, 1, 0, 32'h0);
    // SLVERR on the second beat
    run_burst(32'h4000, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0);
    // early last on beat 2 of 4
    run_burst(32'h5000, 3, 2, 1, 1, 1, -1, 0, 0, 0, 0, 0, 32'h0);
    // missing last: three extra beats discarded
    run_burst(32'h6000, 3, 2, 1, 2, 3, -1, 0, 0, 0, 0, 0, 32'h0);

    // reset with two beats buffered
    @(negedge clk_i);
    valid_i = 1'b1; src_addr_i = 32'h7000; len_i = 8'd3; size_i = 3'd2; burst_i = 2'd1;
    data_ready_i = 1'b0;
    @(negedge clk_i);
    valid_i = 1'b0; m_arready = 1'b1;
    @(negedge clk_i);
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h11; m_rresp = 2'b00; m_rlast = 1'b0;
    @(negedge clk_i);
    m_rdata = 32'h22;
    @(negedge clk_i);
    m_rvalid = 1'b0;
    chk("pre_reset_dvalid", data_valid_o, 1'b1);
    chk("pre_reset_head", data_o, 32'h11);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk_reset_state("midreset");
    run_burst(32'h8000, 0, 2, 1, 0, 0, -1, 0, 0, 0, 0, 0, 32'h0);

    for (int k = 0; k < 8; k++) begin
      len  = $urandom_range(0, 9);
      mode = $urandom_range(0, 2);
      arg  = (mode == 1) ? $urandom_range(0, len) : (mode == 2) ? $urandom_range(1, 3) : 0;
      eidx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : -1;
      run_burst($urandom, len, $urandom_range(0, 5), $urandom_range(0, 2), mode, arg, eidx,
                0, 0, 1, 0, 0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
